// File: rtl/uart_rx.sv
// uart_rx: receiver for 8-bit odd-parity UART frames
// (1 start bit, 8 data bits LSB-first, 1 odd-parity bit, 1 stop bit).
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rx_in       serial line, asynchronous to clk, idles high
//   dout        last received byte (held until the next data_strobe)
//   data_strobe one-cycle pulse; dout and rx_error valid in that cycle
//   rx_error    last frame had a parity or stop-bit error
//   busy        a frame is being received
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       rx_error,
  output logic       busy
);

  localparam int BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_BAUD   = BAUD_CLOCKS / 2;
  localparam int CW          = (BAUD_CLOCKS > 2) ? $clog2(BAUD_CLOCKS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CLOCKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BAUD - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;

  logic baud_clr, bit_clr, bit_inc, shift_en, par_en, done;
  logic fall, baud_end, half_end;

  // Two-flop synchronizer plus one history flop for edge detection.
  // Resetting all three to 0 means a line already low at reset release
  // never looks like a falling edge; it must go high and then low first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall     = rx_prev & ~rx_s2;
  assign baud_end = (baud_cnt == BAUD_LAST);
  assign half_end = (baud_cnt == HALF_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // START waits half a bit to land on the start bit's mid-point; every
  // later state waits a full bit, so each sample stays mid-bit. Leaving
  // STOP at mid-stop gives half a bit of slack for back-to-back frames.
  always_comb begin
    state_nxt = state;
    baud_clr  = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          baud_clr  = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (half_end) begin
          baud_clr = 1'b1;
          if (!rx_s2) begin
            bit_clr   = 1'b1;
            state_nxt = DATA;
          end else begin
            // line back high at mid-start: glitch, drop it silently
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_end) begin
          shift_en = 1'b1;
          baud_clr = 1'b1;
          bit_inc  = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (baud_end) begin
          par_en    = 1'b1;
          baud_clr  = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_end) begin
          done      = 1'b1;
          baud_clr  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timer runs only while a frame is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                baud_cnt <= '0;
    else if (baud_clr)      baud_cnt <= '0;
    else if (state != IDLE) baud_cnt <= baud_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bit_cnt <= 3'd0;
    else if (bit_clr) bit_cnt <= 3'd0;
    else if (bit_inc) bit_cnt <= bit_cnt + 3'd1;
  end

  // LSB arrives first, so shifting right leaves bit 0 in shreg[0]
  // after the eighth sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= 8'h00;
      par_bit <= 1'b0;
    end else begin
      if (shift_en) shreg   <= {rx_s2, shreg[7:1]};
      if (par_en)   par_bit <= rx_s2;
    end
  end

  // Outputs update only on a completed frame; false starts and resets
  // mid-frame leave no trace beyond the reset values themselves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout        <= 8'h00;
      data_strobe <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      data_strobe <= done;
      if (done) begin
        dout     <= shreg;
        // odd parity: data plus parity bit must XOR to 1; stop must be 1
        rx_error <= ~rx_s2 | ~(^{shreg, par_bit});
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx, run at a scaled bit rate (20 clocks/bit)
// so the whole sequence stays short.
module tb_uart_rx;

  localparam int CLKF = 1_000_000;
  localparam int BAUD = 50_000;
  localparam int BC   = CLKF / BAUD;   // 20
  localparam int HB   = BC / 2;        // 10
  localparam int LAT  = 2 + HB + 10 * BC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] dout;
  logic       data_strobe, rx_error, busy;

  uart_rx #(.CLK_FREQUENCY(CLKF), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .dout(dout),
    .data_strobe(data_strobe), .rx_error(rx_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int busy_cnt = 0;
  int last_strobe_cyc = 0;
  logic [7:0] hist_dout [0:63];
  logic       hist_err  [0:63];
  logic       hist_busy [0:63];

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (busy) busy_cnt++;
    if (data_strobe) begin
      if (strobe_cnt < 64) begin
        hist_dout[strobe_cnt] = dout;
        hist_err[strobe_cnt]  = rx_error;
        hist_busy[strobe_cnt] = busy;
      end
      last_strobe_cyc = cyc;
      strobe_cnt++;
    end
  end

  task automatic drive_bit(input logic b);
    rx_in = b;
    repeat (BC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((~^d) ^ par_flip);
    drive_bit(stop_b);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    int s0, b0;
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h want 00", dout); else pass_cnt++;
    total_cnt++; if (data_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", data_strobe); else pass_cnt++;
    total_cnt++; if (rx_error !== 1'b0) $display("FAIL reset_err: got %b want 0", rx_error); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = strobe_cnt;
    b0 = busy_cnt;
    repeat (3 * BC) @(negedge clk);
    total_cnt++; if (busy_cnt !== b0) $display("FAIL low_at_reset_busy: got %0d busy cycles want 0", busy_cnt - b0); else pass_cnt++;
    total_cnt++; if (strobe_cnt !== s0) $display("FAIL low_at_reset_strobe: got %0d strobes want 0", strobe_cnt - s0); else pass_cnt++;
    rx_in = 1'b1;
    repeat (2 * BC) @(negedge clk);
    total_cnt++; if (busy_cnt !== b0) $display("FAIL rise_after_reset_busy: got %0d busy cycles want 0", busy_cnt - b0); else pass_cnt++;
  endtask

  task automatic test_basic;
    int s0, c0, lat;
    logic [7:0] b;
    s0 = strobe_cnt;
    c0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    lat = last_strobe_cyc - c0;
    total_cnt++; if (strobe_cnt !== s0 + 1) $display("FAIL a5_strobes: got %0d want 1", strobe_cnt - s0); else pass_cnt++;
    total_cnt++; if (hist_dout[s0] !== 8'hA5) $display("FAIL a5_dout: got %h want a5", hist_dout[s0]); else pass_cnt++;
    total_cnt++; if (hist_err[s0] !== 1'b0) $display("FAIL a5_err: got %b want 0", hist_err[s0]); else pass_cnt++;
    total_cnt++; if (hist_busy[s0] !== 1'b0) $display("FAIL a5_busy_at_strobe: got %b want 0", hist_busy[s0]); else pass_cnt++;
    total_cnt++; if (lat < LAT - 2 || lat > LAT + 2) $display("FAIL a5_latency: got %0d want %0d+-2", lat, LAT); else pass_cnt++;
    for (int k = 0; k < 20; k++) begin
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(20, 300)) @(negedge clk);
      s0 = strobe_cnt;
      send_frame(b, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      total_cnt++;
      if (strobe_cnt !== s0 + 1 || hist_dout[s0] !== b || hist_err[s0] !== 1'b0)
        $display("FAIL rand_%0d: got n=%0d dout=%h err=%b want n=1 dout=%h err=0",
                 k, strobe_cnt - s0, hist_dout[s0], hist_err[s0], b);
      else pass_cnt++;
    end
  endtask

  task automatic test_errors;
    int s0;
    repeat (2 * BC) @(negedge clk);
    s0 = strobe_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (2 * BC) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2 * BC) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    total_cnt++; if (strobe_cnt !== s0 + 3) $display("FAIL err_strobes: got %0d want 3", strobe_cnt - s0); else pass_cnt++;
    total_cnt++; if (hist_dout[s0] !== 8'h3C) $display("FAIL par_dout: got %h want 3c", hist_dout[s0]); else pass_cnt++;
    total_cnt++; if (hist_err[s0] !== 1'b1) $display("FAIL par_err: got %b want 1", hist_err[s0]); else pass_cnt++;
    total_cnt++; if (hist_dout[s0+1] !== 8'h3C) $display("FAIL stop_dout: got %h want 3c", hist_dout[s0+1]); else pass_cnt++;
    total_cnt++; if (hist_err[s0+1] !== 1'b1) $display("FAIL stop_err: got %b want 1", hist_err[s0+1]); else pass_cnt++;
    total_cnt++; if (hist_dout[s0+2] !== 8'h81) $display("FAIL good_dout: got %h want 81", hist_dout[s0+2]); else pass_cnt++;
    total_cnt++; if (hist_err[s0+2] !== 1'b0) $display("FAIL good_err: got %b want 0", hist_err[s0+2]); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int s0, b0;
    repeat (2 * BC) @(negedge clk);
    s0 = strobe_cnt;
    b0 = busy_cnt;
    rx_in = 1'b0;
    repeat (HB / 2) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * BC) @(negedge clk);
    total_cnt++; if (busy_cnt <= b0) $display("FAIL glitch_busy_pulse: got %0d busy cycles want >0", busy_cnt - b0); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (strobe_cnt !== s0) $display("FAIL glitch_strobe: got %0d want 0", strobe_cnt - s0); else pass_cnt++;
    total_cnt++; if (dout !== 8'h81) $display("FAIL glitch_dout_hold: got %h want 81", dout); else pass_cnt++;
    total_cnt++; if (rx_error !== 1'b0) $display("FAIL glitch_err_hold: got %b want 0", rx_error); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int s0;
    s0 = strobe_cnt;
    // start bit + first three data bits of 0xA5 (1,0,1)
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    total_cnt++; if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_busy_async: got %b want 0", busy); else pass_cnt++;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8 * BC) @(negedge clk);
    total_cnt++; if (strobe_cnt !== s0) $display("FAIL mid_no_strobe: got %0d want 0", strobe_cnt - s0); else pass_cnt++;
    total_cnt++; if (dout !== 8'h00) $display("FAIL mid_dout_reset: got %h want 00", dout); else pass_cnt++;
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    total_cnt++; if (strobe_cnt !== s0 + 1) $display("FAIL after_rst_strobes: got %0d want 1", strobe_cnt - s0); else pass_cnt++;
    total_cnt++; if (hist_dout[s0] !== 8'h5A) $display("FAIL after_rst_dout: got %h want 5a", hist_dout[s0]); else pass_cnt++;
    total_cnt++; if (hist_err[s0] !== 1'b0) $display("FAIL after_rst_err: got %b want 0", hist_err[s0]); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int s0;
    repeat (2 * BC) @(negedge clk);
    s0 = strobe_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    total_cnt++; if (strobe_cnt !== s0 + 2) $display("FAIL b2b_strobes: got %0d want 2", strobe_cnt - s0); else pass_cnt++;
    total_cnt++; if (hist_dout[s0] !== 8'h00) $display("FAIL b2b_first_dout: got %h want 00", hist_dout[s0]); else pass_cnt++;
    total_cnt++; if (hist_err[s0] !== 1'b0) $display("FAIL b2b_first_err: got %b want 0", hist_err[s0]); else pass_cnt++;
    total_cnt++; if (hist_dout[s0+1] !== 8'hFF) $display("FAIL b2b_second_dout: got %h want ff", hist_dout[s0+1]); else pass_cnt++;
    total_cnt++; if (hist_err[s0+1] !== 1'b0) $display("FAIL b2b_second_err: got %b want 0", hist_err[s0+1]); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_errors;
    test_glitch;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that deserializes the 8-bit odd-parity frames produced by the `tx` transmitter. Frame format is 1 start bit (0), 8 data bits LSB-first, 1 odd-parity bit, and 1 stop bit (1). It sits on the serial input pin and hands each received byte to fabric logic with a one-cycle strobe and an error flag. It is also the synthesizable replacement for the `rx_model` simulation model.

Parameters:
- CLK_FREQUENCY, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 19_200: serial bit rate in bits per second.
- Derived: BAUD_CLOCKS = CLK_FREQUENCY / BAUD_RATE (integer division; 5208 at the defaults).
- Derived: HALF_BAUD = BAUD_CLOCKS / 2 (2604 at the defaults).

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- rx_in, input, 1: serial line. Asynchronous to clk; idles high.
- dout, output, 8: last received byte.
- data_strobe, output, 1: one-cycle pulse; dout and rx_error are valid in that cycle.
- rx_error, output, 1: high if the last frame had a parity or stop-bit error.
- busy, output, 1: high while a frame is being received.

Behaviour:
- Reset values: dout=8'h00, data_strobe=0, rx_error=0, busy=0, state=IDLE, all counters=0.
- Input synchronizer:
  - rx_in passes through two flops (rx_s1, rx_s2), then a third flop rx_prev.
  - All three flops reset to 0.
  - Only rx_s2 and rx_prev are used internally.
- Start detect: only a falling edge (rx_prev=1, rx_s2=0) in IDLE starts a frame. A line held low through reset release is ignored until it has gone high and then low again.
- States:
  - IDLE: busy=0. On a falling edge, clear baud_cnt and go to START.
  - START: baud_cnt counts up.
    - At baud_cnt==HALF_BAUD-1, sample rx_s2.
    - If 0: clear baud_cnt and bit_cnt, go to DATA.
    - If 1: false start; go to IDLE with no strobe and no error.
  - DATA: at baud_cnt==BAUD_CLOCKS-1, sample rx_s2 into the shift register (shift right, new bit into the MSB) and clear baud_cnt. After the 8th sample (bit_cnt==7), go to PARITY.
  - PARITY: at baud_cnt==BAUD_CLOCKS-1, capture the parity bit and clear baud_cnt, then go to STOP.
  - STOP: at baud_cnt==BAUD_CLOCKS-1, sample the stop bit. On that edge:
    - dout <= shift register;
    - data_strobe <= 1 for exactly one cycle;
    - rx_error <= (stop bit == 0) OR (XOR of 8 data bits and parity bit != 1);
    - go to IDLE.
- Sample points: every bit is sampled at its nominal mid-point. Returning to IDLE at mid-stop allows back-to-back frames with no extra idle time.
- busy: high in START, DATA, PARITY and STOP; low in the cycle data_strobe is high.
- Output hold: dout and rx_error hold their values until the next data_strobe. They are not cleared by a false start.
- Latency: data_strobe rises about 2 + HALF_BAUD + 10*BAUD_CLOCKS clocks after the rx_in falling edge, i.e. 54_686 clocks ±2 at the defaults.
- Reset mid-frame: everything returns to reset values immediately (asynchronously) and no strobe is emitted. The partial frame is discarded. The next start is taken only on a fresh falling edge.
- Line stuck low: a stop bit of 0 gives a strobe with rx_error=1. No new frame starts until the line goes high and then low.
- Counters: baud_cnt is wide enough for BAUD_CLOCKS-1 (13 bits at the defaults). bit_cnt is 3 bits.

Test Plan:
1. Reset with rx_in high → all outputs 0 and busy=0. Then rx_in low for 2 clocks during reset and held low after release → no busy, no strobe.
2. Drive byte 0xA5 with correct odd parity (parity bit=1) at 19_200 baud → one data_strobe, dout=8'hA5, rx_error=0, busy low at strobe. Repeat for 20 random bytes driven by `tx` with random gaps of 1000–30000 clocks; every byte must match.
3. Drive 0x3C with the parity bit inverted → dout=8'h3C, rx_error=1. Drive 0x3C with the stop bit at 0 → rx_error=1. A following good frame 0x81 → rx_error=0.
4. Low glitch of 1000 clocks (shorter than HALF_BAUD) on an idle line → busy pulses, then returns to 0 with no strobe, and dout keeps its prior value.
5. Assert rst 4 baud periods into frame 0xA5 → busy=0 within 1 clock and no strobe. The next full frame 0x5A is received correctly.
6. Two frames back-to-back (0x00 then 0xFF) with zero idle between them → two strobes, dout=8'h00 then 8'hFF, rx_error=0 for both.
